// File: rtl/pdm_pkg.sv
// Shared constants and helpers for the PDM modulator/decimator family.
// Offset-binary PCM: 0x00000000 = -full-scale, 0x80000000 = midscale.
package pdm_pkg;

    localparam logic [31:0] PDM_MIDSCALE = 32'h8000_0000;
    localparam logic [31:0] PDM_FS_NEG   = 32'h0000_0000;
    localparam logic [31:0] PDM_FS_POS   = 32'hFFFF_FFFF;

    typedef enum logic {
        EDGE_RISE = 1'b0,
        EDGE_FALL = 1'b1
    } pdm_edge_e;

    // Signed CIC register width: order*log2(decim) growth plus sign and headroom.
    function automatic int cic_width(input int order, input int decim);
        return order * $clog2(decim) + 2;
    endfunction

endpackage

// File: rtl/pdm_sync_edge.sv
// Synchronises the PDM bit clock and data into clk and emits a one-cycle
// tick with the captured data bit on the selected ock edge.
module pdm_sync_edge #(
    parameter int EDGE = 0
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_ock,
    input  logic i_sdi,
    input  logic i_en,
    output logic o_tick,
    output logic o_bit
);
    import pdm_pkg::*;

    logic [1:0] r_ock_s;
    logic [1:0] r_sdi_s;
    logic       r_ock_d;
    logic       r_tick;
    logic       r_bit;
    logic       w_edge;

    assign w_edge = (EDGE == int'(EDGE_FALL)) ? (~r_ock_s[1] & r_ock_d)
                                              : (r_ock_s[1] & ~r_ock_d);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ock_s <= '0;
            r_sdi_s <= '0;
            r_ock_d <= 1'b0;
            r_tick  <= 1'b0;
            r_bit   <= 1'b0;
        end else begin
            r_ock_s <= {r_ock_s[0], i_ock};
            r_sdi_s <= {r_sdi_s[0], i_sdi};
            if (!i_en) begin
                r_ock_d <= 1'b0;
                r_tick  <= 1'b0;
                r_bit   <= 1'b0;
            end else begin
                r_ock_d <= r_ock_s[1];
                r_tick  <= w_edge;
                if (w_edge) begin
                    r_bit <= r_sdi_s[1];
                end
            end
        end
    end

    assign o_tick = r_tick;
    assign o_bit  = r_bit;

endmodule

// File: rtl/pdm_cic_decimator.sv
// CIC decimator: 1-bit PDM in, ORDER integrators at the tick rate,
// ORDER pipelined combs at the output rate, offset-binary 32-bit PCM out.
module pdm_cic_decimator #(
    parameter int ORDER = 4,
    parameter int DECIM = 64,
    parameter int EDGE  = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ock,
    input  logic        sdi,
    input  logic        en,
    output logic [31:0] dout,
    output logic        valid
);
    import pdm_pkg::*;

    localparam int LOGD  = $clog2(DECIM);
    localparam int W     = cic_width(ORDER, DECIM);
    localparam int SHIFT = 33 - W;
    localparam logic [W-1:0] C_FULL = W'(1) << (ORDER * LOGD);

    logic             w_tick;
    logic             w_bit;
    logic             w_dec;
    logic [W-1:0]     w_x;
    logic [W-1:0]     w_u;
    logic [W-2:0]     w_uc;
    logic [31:0]      w_fmt;

    logic [W-1:0]     r_int [ORDER];
    logic [W-1:0]     r_cmb [ORDER];
    logic [W-1:0]     r_dly [ORDER];
    logic [ORDER-1:0] r_stg;
    logic [LOGD-1:0]  r_cnt;

    pdm_sync_edge #(
        .EDGE (EDGE)
    ) u_sync (
        .clk    (clk),
        .rstn   (rstn),
        .i_ock  (ock),
        .i_sdi  (sdi),
        .i_en   (en),
        .o_tick (w_tick),
        .o_bit  (w_bit)
    );

    assign w_x   = w_bit ? W'(1) : '1;
    assign w_dec = w_tick && (r_cnt == '1);

    // Integrators and tick counter; every stage reads pre-update values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < ORDER; k++) begin
                r_int[k] <= '0;
            end
            r_cnt <= '0;
        end else if (!en) begin
            for (int k = 0; k < ORDER; k++) begin
                r_int[k] <= '0;
            end
            r_cnt <= '0;
        end else if (w_tick) begin
            r_int[0] <= r_int[0] + w_x;
            for (int k = 1; k < ORDER; k++) begin
                r_int[k] <= r_int[k] + r_int[k-1];
            end
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Comb stage k fires k cycles after dec; stage 0 takes the
    // last integrator directly on the dec cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < ORDER; k++) begin
                r_cmb[k] <= '0;
                r_dly[k] <= '0;
            end
            r_stg <= '0;
        end else if (!en) begin
            for (int k = 0; k < ORDER; k++) begin
                r_cmb[k] <= '0;
                r_dly[k] <= '0;
            end
            r_stg <= '0;
        end else begin
            r_stg[0] <= w_dec;
            for (int k = 1; k < ORDER; k++) begin
                r_stg[k] <= r_stg[k-1];
            end
            if (w_dec) begin
                r_cmb[0] <= r_int[ORDER-1] - r_dly[0];
                r_dly[0] <= r_int[ORDER-1];
            end
            for (int k = 1; k < ORDER; k++) begin
                if (r_stg[k-1]) begin
                    r_cmb[k] <= r_cmb[k-1] - r_dly[k];
                    r_dly[k] <= r_cmb[k-1];
                end
            end
        end
    end

    // Shift to unsigned; only +full-scale overflows W-1 bits, so clamp it.
    assign w_u   = r_cmb[ORDER-1] + C_FULL;
    assign w_uc  = w_u[W-1] ? '1 : w_u[W-2:0];
    assign w_fmt = 32'(w_uc) << SHIFT;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= en & r_stg[ORDER-1];
            if (en && r_stg[ORDER-1]) begin
                dout <= w_fmt;
            end
        end
    end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Randomised bench for pdm_cic_decimator against a convolution-based
// CIC reference (box filter raised to ORDER) on the recorded samples.
module tb_pdm_cic_decimator;

    localparam int ORDER = 4;
    localparam int DECIM = 64;
    localparam int LOGD  = $clog2(DECIM);
    localparam int W     = ORDER * LOGD + 2;
    localparam int HL    = ORDER * (DECIM - 1) + 1;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic        ock  = 1'b0;
    logic        sdi  = 1'b0;
    logic        en   = 1'b0;
    logic [31:0] dout0;
    logic [31:0] dout1;
    logic        valid0;
    logic        valid1;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          xs0[$];
    int          xs1[$];
    int          np0 = 0;
    int          np1 = 0;
    logic [31:0] last0 = '0;
    logic [31:0] last1 = '0;
    logic        pv0 = 1'b0;
    logic        pv1 = 1'b0;
    longint      h [HL];

    always #5 clk = ~clk;

    pdm_cic_decimator #(
        .ORDER (ORDER),
        .DECIM (DECIM),
        .EDGE  (0)
    ) u_dut_l (
        .clk   (clk),
        .rstn  (rstn),
        .ock   (ock),
        .sdi   (sdi),
        .en    (en),
        .dout  (dout0),
        .valid (valid0)
    );

    pdm_cic_decimator #(
        .ORDER (ORDER),
        .DECIM (DECIM),
        .EDGE  (1)
    ) u_dut_r (
        .clk   (clk),
        .rstn  (rstn),
        .ock   (ock),
        .sdi   (sdi),
        .en    (en),
        .dout  (dout1),
        .valid (valid1)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Output d is the ORDER-fold box filter over samples ending at
    // tick d*DECIM+DECIM-1-ORDER; samples before time 0 count as zero.
    function automatic logic [31:0] ref_dout(input int ch, input int d);
        longint acc = 0;
        longint dn;
        longint u;
        int     nd;
        int     idx;
        int     v;
        nd = d * DECIM + DECIM - 1;
        for (int k = 0; k < HL; k++) begin
            idx = nd - ORDER - k;
            if (idx < 0) break;
            v = 0;
            if (ch == 0 && idx < xs0.size()) v = xs0[idx];
            if (ch == 1 && idx < xs1.size()) v = xs1[idx];
            acc += h[k] * longint'(v);
        end
        dn = longint'(1) << (ORDER * LOGD);
        u  = acc + dn;
        if (u > 2 * dn - 1) u = 2 * dn - 1;
        return 32'(u << (33 - W));
    endfunction

    always @(negedge clk) begin
        if (rstn) begin
            if (valid0) begin
                check("l_pulse_width", 32'(pv0), 32'd0);
                last0 = ref_dout(0, np0);
                check("l_dout", dout0, last0);
                np0++;
            end
            if (valid1) begin
                check("r_pulse_width", 32'(pv1), 32'd0);
                last1 = ref_dout(1, np1);
                check("r_dout", dout1, last1);
                np1++;
            end
        end
        pv0 = valid0;
        pv1 = valid1;
    end

    task automatic rise(input bit l);
        @(negedge clk) sdi = l;
        @(negedge clk) ock = 1'b1;
        if (en) xs0.push_back(l ? 1 : -1);
        @(negedge clk);
    endtask

    task automatic fall(input bit r);
        @(negedge clk) sdi = r;
        @(negedge clk) ock = 1'b0;
        if (en) xs1.push_back(r ? 1 : -1);
        @(negedge clk);
    endtask

    task automatic ock_cycle(input bit l, input bit r);
        rise(l);
        fall(r);
    endtask

    task automatic settle();
        repeat (12) @(negedge clk);
    endtask

    task automatic clear_model();
        xs0.delete();
        xs1.delete();
        np0 = 0;
        np1 = 0;
    endtask

    task automatic align_to_dec();
        for (int i = 0; i < DECIM && (xs0.size() % DECIM) != DECIM - 1; i++) begin
            ock_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        longint t [HL];
        int     n;
        int     vcnt;
        bit     got;

        for (int j = 0; j < HL; j++) h[j] = 0;
        h[0] = 1;
        repeat (ORDER) begin
            for (int j = 0; j < HL; j++) begin
                t[j] = 0;
                for (int i = 0; i < DECIM && i <= j; i++) t[j] += h[j-i];
            end
            for (int j = 0; j < HL; j++) h[j] = t[j];
        end

        repeat (4) @(negedge clk);
        check("rst_dout_l", dout0, 32'h0);
        check("rst_dout_r", dout1, 32'h0);
        check("rst_valid", 32'({valid1, valid0}), 32'd0);
        rstn = 1'b1;
        @(negedge clk) en = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 8192; i++) ock_cycle(1'b1, 1'b1);
        settle();
        check("ones_pulses_l", 32'(np0), 32'd128);
        check("ones_pulses_r", 32'(np1), 32'd128);
        check("ones_dout_l", dout0, 32'hFFFF_FF80);
        check("ones_dout_r", dout1, 32'hFFFF_FF80);

        for (int i = 0; i < 6 * DECIM; i++) ock_cycle(1'b0, 1'b0);
        settle();
        check("zeros_dout_l", dout0, 32'h0000_0000);
        check("zeros_dout_r", dout1, 32'h0000_0000);

        for (int i = 0; i < 6 * DECIM; i++) ock_cycle(1'(i), 1'(i));
        settle();
        check("alt_dout_l", dout0, 32'h8000_0000);
        check("alt_dout_r", dout1, 32'h8000_0000);

        for (int i = 0; i < 6 * DECIM; i++) ock_cycle(1'b1, 1'b0);
        settle();
        check("stereo_l", dout0, 32'hFFFF_FF80);
        check("stereo_r", dout1, 32'h0000_0000);

        for (int i = 0; i < 1000; i++) begin
            ock_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        settle();

        align_to_dec();
        @(negedge clk) sdi = 1'b1;
        @(negedge clk) ock = 1'b1;
        xs0.push_back(1);
        n   = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (valid0) got = 1'b1;
        end
        check("lat_seen", 32'(got), 32'd1);
        check("lat_ock_to_valid", 32'(n), 32'd8);
        fall(1'b0);
        settle();

        align_to_dec();
        @(negedge clk) sdi = 1'b1;
        @(negedge clk) ock = 1'b1;
        xs0.push_back(1);
        repeat (5) @(posedge clk);
        @(negedge clk) rstn = 1'b0;
        ock = 1'b0;
        sdi = 1'b0;
        clear_model();
        vcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (valid0 || valid1) vcnt++;
        end
        check("rst_mid_novalid", 32'(vcnt), 32'd0);
        check("rst_mid_dout_l", dout0, 32'h0);
        check("rst_mid_dout_r", dout1, 32'h0);
        @(negedge clk) rstn = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < DECIM - 1; i++) begin
            ock_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        settle();
        check("rst_early_l", 32'(np0), 32'd0);
        check("rst_early_r", 32'(np1), 32'd0);
        ock_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        settle();
        check("rst_first_l", 32'(np0), 32'd1);
        check("rst_first_r", 32'(np1), 32'd1);

        for (int i = 0; i < 200; i++) begin
            ock_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        settle();
        @(negedge clk) en = 1'b0;
        clear_model();
        repeat (1000) @(negedge clk);
        for (int i = 0; i < 100; i++) ock_cycle(1'b1, 1'b0);
        settle();
        check("en_novalid_l", 32'(np0), 32'd0);
        check("en_novalid_r", 32'(np1), 32'd0);
        check("en_hold_l", dout0, last0);
        check("en_hold_r", dout1, last1);
        @(negedge clk) en = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < DECIM - 1; i++) ock_cycle(1'b1, 1'b0);
        settle();
        check("en_early_l", 32'(np0), 32'd0);
        check("en_early_r", 32'(np1), 32'd0);
        ock_cycle(1'b1, 1'b0);
        settle();
        check("en_first_l", 32'(np0), 32'd1);
        check("en_first_r", 32'(np1), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
